// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// master drives operands and out_ready; slave is the adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined 4-bit-group CLA adder/subtractor, one slice per stage.
// Define CLA_PIPE_FLAGS_EN to build the registered ovf/zero flags.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  function automatic logic [SW:0] slice_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] g, p, s;
    logic [3:0]    gg, pp;
    logic          c, c1, c2, c3, gG, gP;
    g = x & y;
    p = x ^ y;
    s = '0;
    c = ci;
    for (int j = 0; j < NG; j++) begin
      gg = g[4*j +: 4];
      pp = p[4*j +: 4];
      c1 = gg[0] | (pp[0] & c);
      c2 = gg[1] | (pp[1] & gg[0])
         | (pp[1] & pp[0] & c);
      c3 = gg[2] | (pp[2] & gg[1])
         | (pp[2] & pp[1] & gg[0])
         | (pp[2] & pp[1] & pp[0] & c);
      gG = gg[3] | (pp[3] & gg[2])
         | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0]);
      gP = &pp;
      s[4*j +: 4] = pp ^ {c3, c2, c1, c};
      c = gG | (gP & c);
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  bp_q [STAGES];
  logic [WIDTH-1:0]  bp_d [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;

  logic [WIDTH-1:0] bp_in, sa, sb, ss;
  logic             sc, sv;
  logic [SW:0]      r;
  logic             adv;

  assign adv = !v_q[STAGES-1] || bus.out_ready;

  // Each stage resolves its own slice; the rest rides along as skew.
  always_comb begin
    bp_in = bus.sub ? ~bus.b : bus.b;
    sa    = '0;
    sb    = '0;
    ss    = '0;
    sc    = 1'b0;
    sv    = 1'b0;
    r     = '0;
    a_d   = a_q;
    bp_d  = bp_q;
    s_d   = s_q;
    v_d   = v_q;
    c_d   = c_q;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sa = bus.a;
        sb = bp_in;
        sc = bus.sub | bus.cin;
        sv = bus.in_valid;
        ss = '0;
      end else begin
        sa = a_q[k > 0 ? k-1 : 0];
        sb = bp_q[k > 0 ? k-1 : 0];
        sc = c_q[k > 0 ? k-1 : 0];
        sv = v_q[k > 0 ? k-1 : 0];
        ss = s_q[k > 0 ? k-1 : 0];
      end
      r = slice_add(sa[k*SW +: SW], sb[k*SW +: SW], sc);
      ss[k*SW +: SW] = r[SW-1:0];
      a_d[k]  = sa;
      bp_d[k] = sb;
      s_d[k]  = ss;
      c_d[k]  = r[SW];
      v_d[k]  = sv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '{default: '0};
      bp_q <= '{default: '0};
      s_q  <= '{default: '0};
      v_q  <= '0;
      c_q  <= '0;
    end else if (adv) begin
      a_q  <= a_d;
      bp_q <= bp_d;
      s_q  <= s_d;
      v_q  <= v_d;
      c_q  <= c_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  // Carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    ovf_d  = c_d[STAGES-1]
           ^ (sa[WIDTH-1] ^ sb[WIDTH-1] ^ ss[WIDTH-1]);
    zero_d = ~|ss;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif
endmodule
